// File: rtl/dmem_pkg.sv
// Shared types and constants for the M-stage data-port bridge (dmem_bridge).
package dmem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } dmemStateT;

  localparam int          WORD_ADDR_W  = 30;
  localparam logic [31:0] TIMEOUT_DATA = 32'h0;
endpackage

// File: rtl/dmem_wbuf.sv
// One-entry posted write buffer for dmem_bridge; compiled only when DMEM_WBUF_EN is defined.
`ifdef DMEM_WBUF_EN
module dmem_wbuf
  import dmem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fill,
  input  logic [WORD_ADDR_W-1:0] fillAddr,
  input  logic [31:0]            fillData,
  input  logic                   drainDone,
  input  logic [WORD_ADDR_W-1:0] lookupAddr,
  output logic                   bufValid,
  output logic [WORD_ADDR_W-1:0] bufAddr,
  output logic [31:0]            bufData,
  output logic                   hit
);
  // Fill only happens with the buffer empty, drain only with it full, so they never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bufValid <= 1'b0;
      bufAddr  <= '0;
      bufData  <= '0;
    end else if (fill) begin
      bufValid <= 1'b1;
      bufAddr  <= fillAddr;
      bufData  <= fillData;
    end else if (drainDone) begin
      bufValid <= 1'b0;
    end
  end

  assign hit = bufValid && (bufAddr == lookupAddr);
endmodule
`endif

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns M-stage load/store strobes into a req/ready + rvalid bus transaction,
// freezing the pipeline meanwhile; response timeout sets sticky bus_err. DMEM_WBUF_EN adds a posted write buffer.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MemReadM,
  input  logic                   MemWriteM,
  input  logic [31:0]            ALUResultM,
  input  logic [31:0]            WriteDataM,
  output logic [31:0]            ReadDataM,
  output logic                   MemStallM,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [WORD_ADDR_W-1:0] mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_ready,
  input  logic                   mem_rvalid,
  input  logic [31:0]            mem_rdata,
  output logic                   bus_err,
  output dmemStateT              dbgState
);
  // Handshake: a request transfers on a rising edge where mem_req && mem_ready; the read
  // response transfers on an edge where mem_rvalid is high while in RESP. Both are ignored elsewhere.
  localparam logic [15:0] LAST_WAIT = 16'(MAX_WAIT - 1);

  dmemStateT              state, nextState;
  logic [15:0]            waitCnt;
  logic                   reqQ, weQ, errQ;
  logic [WORD_ADDR_W-1:0] addrQ;
  logic [31:0]            wdataQ, rdataQ;
  logic                   issue, timeout, timeUp, busyHold, doneHold;
  logic                   latchWe;
  logic [WORD_ADDR_W-1:0] latchAddr, coreAddr;
  logic [31:0]            latchData;
  logic                   unusedByteSel;

  assign coreAddr      = ALUResultM[31:2];
  assign unusedByteSel = ^ALUResultM[1:0];
  assign timeUp        = (waitCnt >= LAST_WAIT);

`ifdef DMEM_WBUF_EN
  logic                   drainQ, drainStart, fill, drainDone, bufValid, bufHit, coreWait;
  logic [WORD_ADDR_W-1:0] bufAddr;
  logic [31:0]            bufData;

  dmem_wbuf uWbuf (
    .clk(clk), .rst(rst), .fill(fill), .fillAddr(coreAddr), .fillData(WriteDataM),
    .drainDone(drainDone), .lookupAddr(coreAddr), .bufValid(bufValid),
    .bufAddr(bufAddr), .bufData(bufData), .hit(bufHit)
  );

  assign drainDone = (state == DONE) && drainQ;
  // During a background drain only a load that hits the buffer may proceed.
  assign coreWait  = MemWriteM || (MemReadM && !bufHit);
  assign busyHold  = drainQ ? coreWait : 1'b1;
  assign doneHold  = drainQ && coreWait;
  assign ReadDataM = (MemReadM && !MemWriteM && bufHit) ? bufData : rdataQ;
`else
  assign busyHold  = 1'b1;
  assign doneHold  = 1'b0;
  assign ReadDataM = rdataQ;
`endif

  always_comb begin
    nextState = state;
    issue     = 1'b0;
    timeout   = 1'b0;
    MemStallM = 1'b0;
    latchWe   = MemWriteM;
    latchAddr = coreAddr;
    latchData = WriteDataM;
`ifdef DMEM_WBUF_EN
    drainStart = 1'b0;
    fill       = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef DMEM_WBUF_EN
        if (bufValid) begin
          drainStart = 1'b1;
          issue      = 1'b1;
          latchWe    = 1'b1;
          latchAddr  = bufAddr;
          latchData  = bufData;
          nextState  = REQ;
          MemStallM  = coreWait;
        end else if (MemWriteM) begin
          fill = 1'b1;
        end else if (MemReadM) begin
          issue     = 1'b1;
          nextState = REQ;
          MemStallM = 1'b1;
        end
`else
        if (MemReadM || MemWriteM) begin
          issue     = 1'b1;
          nextState = REQ;
          MemStallM = 1'b1;
        end
`endif
      end
      REQ: begin
        MemStallM = busyHold;
        if (mem_ready) begin
          nextState = weQ ? DONE : RESP;
        end else if (timeUp) begin
          timeout   = 1'b1;
          nextState = DONE;
        end
      end
      RESP: begin
        MemStallM = busyHold;
        if (mem_rvalid) begin
          nextState = DONE;
        end else if (timeUp) begin
          timeout   = 1'b1;
          nextState = DONE;
        end
      end
      DONE: begin
        MemStallM = doneHold;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      waitCnt <= '0;
      reqQ    <= 1'b0;
      weQ     <= 1'b0;
      addrQ   <= '0;
      wdataQ  <= '0;
      rdataQ  <= '0;
      errQ    <= 1'b0;
`ifdef DMEM_WBUF_EN
      drainQ  <= 1'b0;
`endif
    end else begin
      state <= nextState;
      reqQ  <= (nextState == REQ);
      if (issue) begin
        weQ     <= latchWe;
        addrQ   <= latchAddr;
        wdataQ  <= latchData;
        waitCnt <= '0;
      end else if (state == REQ || state == RESP) begin
        waitCnt <= waitCnt + 16'd1;
      end
      if (state == RESP && mem_rvalid) rdataQ <= mem_rdata;
      if (timeout) begin
        rdataQ <= TIMEOUT_DATA;
        errQ   <= 1'b1;
      end
`ifdef DMEM_WBUF_EN
      if (issue) drainQ <= drainStart;
`endif
    end
  end

  assign mem_req   = reqQ;
  assign mem_we    = weQ;
  assign mem_addr  = addrQ;
  assign mem_wdata = wdataQ;
  assign bus_err   = errQ;
  assign dbgState  = state;
endmodule

// File: tb/tb_dmem_bridge.sv
// Randomized self-checking bench for dmem_bridge: a latency-programmable RAM responder plus
// a transaction-level model predicting stall length, read data and RAM writes.
module tb_dmem_bridge;
  import dmem_pkg::*;

  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        MemStallM, mem_req, mem_we, mem_ready, mem_rvalid, bus_err;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  dmemStateT   dbgState;

  dmem_bridge #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
    .MemStallM(MemStallM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .bus_err(bus_err), .dbgState(dbgState)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          nVec = 0;
  int          nFail = 0;
  logic [31:0] expQ[$];
  logic [31:0] expRam [logic [29:0]];

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- RAM responder ----------------
  logic [31:0] ram [logic [29:0]];
  int          readyDly = 0, rvalidDly = 0, writeCount = 0, readCount = 0;
  int          reqCnt = 0, respLeft = 0;
  bit          rdPending = 0;
  logic [29:0] rdAddr = '0;

  function automatic logic [31:0] fillPattern(input logic [29:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] ramRead(input logic [29:0] a);
    return ram.exists(a) ? ram[a] : fillPattern(a);
  endfunction

  function automatic logic [31:0] expRead(input logic [29:0] a);
    return expRam.exists(a) ? expRam[a] : fillPattern(a);
  endfunction

  initial begin
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (!rst && mem_req && mem_ready) begin
        if (mem_we) begin
          ram[mem_addr] = mem_wdata;
          writeCount++;
        end else begin
          readCount++;
          rdPending = 1;
          respLeft  = rvalidDly;
          rdAddr    = mem_addr;
        end
      end
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      if (rst) begin
        rdPending = 0;
        reqCnt    = 0;
        mem_ready = 1'b0;
      end else begin
        if (rdPending) begin
          if (respLeft == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = ramRead(rdAddr);
            rdPending  = 0;
          end else begin
            respLeft--;
          end
        end
        if (mem_req) begin
          mem_ready = (reqCnt == readyDly);
          reqCnt++;
        end else begin
          mem_ready = 1'b0;
          reqCnt    = 0;
        end
      end
    end
  end

  // ---------------- core-side driver ----------------
  int lastReqCycles = 0;

  task automatic coreOp(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output int stalls, output logic [31:0] data,
                        output int reqCycles, output logic [29:0] busAddr, output int busBad);
    bit done;
    int c;
    done = 0;
    c = 0;
    MemReadM = rd; MemWriteM = wr; ALUResultM = addr; WriteDataM = wdata;
    stalls = 0; reqCycles = 0; busBad = 0; data = '0; busAddr = '0;
    while (!done && c < 200) begin
      @(negedge clk);
      c++;
      if (mem_req) begin
        if (reqCycles == 0) busAddr = mem_addr;
        reqCycles++;
        if (mem_addr !== addr[31:2] || mem_we !== wr || (wr && mem_wdata !== wdata)) busBad++;
      end
      if (MemStallM) stalls++;
      else begin
        data = ReadDataM;
        done = 1;
      end
    end
    checkEq("op_done", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    MemReadM = 1'b0;
    MemWriteM = 1'b0;
  endtask

  // Transaction-level model: stall = 1 issue cycle + bus wait cycles, capped by the timeout.
  task automatic runOp(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int rdy, input int rv);
    int          expStalls, stalls, reqCycles, busBad, w0, waitCycles;
    bit          timedOut;
    logic [31:0] data;
    logic [29:0] busAddr, wa;
    wa = addr[31:2];
    readyDly = rdy;
    rvalidDly = rv;
    waitCycles = wr ? rdy + 1 : rdy + rv + 2;
    timedOut = waitCycles > MAX_WAIT;
    expStalls = 1 + (timedOut ? MAX_WAIT : waitCycles);
    if (wr) begin
      if (!timedOut) expRam[wa] = wdata;
    end else begin
      expQ.push_back(timedOut ? 32'h0 : expRead(wa));
    end
    w0 = writeCount;
    coreOp(rd, wr, addr, wdata, stalls, data, reqCycles, busAddr, busBad);
    lastReqCycles = reqCycles;
    checkEq({tag, "_stall"}, stalls, expStalls);
    checkEq({tag, "_addr"}, {2'b00, busAddr}, {2'b00, wa});
    checkEq({tag, "_bus_stable"}, busBad, 0);
    checkEq({tag, "_writes"}, writeCount - w0, (wr && !timedOut) ? 1 : 0);
    if (!wr) checkEq({tag, "_rdata"}, data, expQ.pop_front());
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r0, w0, stalls, rc, bad;
    logic [31:0] data;
    logic [29:0] ba;

    rst = 1'b1;
    MemReadM = 1'b0; MemWriteM = 1'b0; ALUResultM = '0; WriteDataM = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkEq("rst_mem_req", mem_req, 0);
    checkEq("rst_mem_we", mem_we, 0);
    checkEq("rst_mem_addr", {2'b00, mem_addr}, 0);
    checkEq("rst_mem_wdata", mem_wdata, 0);
    checkEq("rst_rdata", ReadDataM, 0);
    checkEq("rst_bus_err", bus_err, 0);
    checkEq("rst_stall", MemStallM, 0);
    checkEq("rst_state", 32'(dbgState), 32'(IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    ram[30'h4] = 32'hCAFEF00D;
    expRam[30'h4] = 32'hCAFEF00D;
    runOp("ld_cafe", 1'b1, 1'b0, 32'h10, 32'h0, 0, 0);

`ifndef DMEM_WBUF_EN
    runOp("st_slow", 1'b0, 1'b1, 32'h20, 32'h12345678, 5, 0);
    checkEq("st_slow_req_cycles", lastReqCycles, 6);
    checkEq("st_slow_ram", ram[30'h8], 32'h12345678);

    r0 = readCount;
    runOp("both", 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1, 0);
    checkEq("both_no_read", readCount - r0, 0);
    checkEq("both_ram", ram[30'h10], 32'hDEADBEEF);
`endif

    for (int i = 0; i < 40; i++) begin
      logic        wr;
      logic [31:0] a;
`ifdef DMEM_WBUF_EN
      wr = 1'b0;
`else
      wr = 1'($urandom_range(0, 1));
`endif
      a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      runOp("rnd", ~wr, wr, a, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end
    checkEq("rnd_no_err", bus_err, 0);

`ifdef DMEM_WBUF_EN
    readyDly = 2;
    w0 = writeCount;
    expRam[30'h20] = 32'hA5A5A5A5;
    coreOp(1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, stalls, data, rc, ba, bad);
    checkEq("wbuf_st_stall", stalls, 0);
    coreOp(1'b1, 1'b0, 32'h80, 32'h0, stalls, data, rc, ba, bad);
    checkEq("wbuf_ld_stall", stalls, 0);
    checkEq("wbuf_ld_data", data, 32'hA5A5A5A5);
    for (int c = 0; c < 30 && writeCount == w0; c++) @(negedge clk);
    checkEq("wbuf_drain_writes", writeCount - w0, 1);
    checkEq("wbuf_drain_ram", ram[30'h20], 32'hA5A5A5A5);
    repeat (3) @(posedge clk);
    #1;
`endif

    runOp("tmo", 1'b1, 1'b0, 32'h100, 32'h0, 0, 20);
    @(negedge clk);
    checkEq("tmo_bus_err", bus_err, 1);
    checkEq("tmo_state_idle", 32'(dbgState), 32'(IDLE));
    repeat (100) @(posedge clk);
    @(negedge clk);
    checkEq("tmo_err_sticky", bus_err, 1);
    checkEq("tmo_late_rvalid_ignored", ReadDataM, 0);
    checkEq("tmo_still_idle", 32'(dbgState), 32'(IDLE));

    @(posedge clk);
    #1;
    readyDly = 0;
    rvalidDly = 50;
    MemReadM = 1'b1;
    ALUResultM = 32'h44;
    repeat (3) @(negedge clk);
    checkEq("rst_mid_pre_state", 32'(dbgState), 32'(RESP));
    #2;
    rst = 1'b1;
    MemReadM = 1'b0;
    #1;
    checkEq("rst_mid_req", mem_req, 0);
    checkEq("rst_mid_state", 32'(dbgState), 32'(IDLE));
    checkEq("rst_mid_addr", {2'b00, mem_addr}, 0);
    checkEq("rst_mid_rdata", ReadDataM, 0);
    checkEq("rst_mid_bus_err", bus_err, 0);
    checkEq("rst_mid_stall", MemStallM, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    runOp("post_rst", 1'b1, 1'b0, 32'h44, 32'h0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
